bcd_game_timer: RTL and testbench
=================================

// Module: bcd_game_timer
// PURPOSE
//  Parametrised BCD game timer. Counts up or down at a selectable rate over DIGITS decimal digits.
//  Supports load, start, pause, and a terminal-count flag.
//  Feeds the HEX displays through per-digit hex_decoder instances; the game FSM consumes Expired/Done.
//  Replaces the fixed 2-digit up-counter with a run/pause/done timer.
// PARAMETERS
//  CLOCK_FREQUENCY  50000000  ClockIn cycles per 1x tick (1 s at 50 MHz)
//  DIGITS           2         number of BCD digits (1..8)
//  CNT_W            27        divider width; must satisfy 2**CNT_W > CLOCK_FREQUENCY
// PORTS
//  ClockIn    in   1         system clock; all logic on posedge
//  Reset      in   1         synchronous, active-high reset
//  Load       in   1         1-cycle strobe: capture LoadValue, go IDLE
//  LoadValue  in   4*DIGITS  BCD start value, digit 0 in [3:0]
//  Start      in   1         1-cycle strobe: IDLE/DONE -> RUN
//  Pause      in   1         level: hold count while high
//  Up         in   1         1 = count up, 0 = count down; sampled at Start
//  Speed      in   2         tick rate: 00=1x 01=2x 10=4x 11=8x
//  Digits     out  4*DIGITS  current BCD count
//  Running    out  1         high in RUN state only
//  Expired    out  1         1-cycle pulse on reaching terminal value
//  Done       out  1         high in DONE state
// BEHAVIOUR
//  Reset: state=IDLE, Digits=0, start register=0, divider=period-1.
//         Running=0, Expired=0, Done=0, latched direction=down.
//  Priority per cycle: Reset > Load > Start > Pause > tick.
//  States:
//   IDLE -Start-> RUN
//   RUN -Pause-> PAUSED; PAUSED -!Pause-> RUN
//   RUN -terminal reached-> DONE
//   DONE -Start-> RUN (Digits reloaded from start register)
//   Any state -Load-> IDLE
//  Load: start register and Digits <= LoadValue. Each nibble > 9 is clamped to 9. Divider restarts.
//  Start: latch Up. Divider restarts at period-1, so the first tick is a full period later.
//  Start while RUN/PAUSED is ignored.
//  Start with a count already terminal goes to DONE the next cycle, with Expired pulsed.
//  Tick generator (sub-module):
//   period = CLOCK_FREQUENCY >> Speed.
//   Count down to 0, emit tick for 1 cycle, reload period-1.
//   Counts only in RUN and holds its value in PAUSED, so partial periods are preserved.
//   A Speed change takes effect at the next reload.
//  Count update: tick in cycle k -> Digits updated at edge ending cycle k (visible in cycle k+1).
//   Down: BCD decrement with borrow ripple (digit 0 -> 9, borrow to next). Terminal = all zeros.
//   Up: BCD increment with carry ripple (digit 9 -> 0, carry to next). Terminal = all nines.
//  Expired: asserts in the same cycle Digits first shows the terminal value, with state=DONE; 1 cycle.
//  DONE: Digits frozen at the terminal value; ticks ignored.
//  Pause arriving in the same cycle as a tick: the tick is applied and the state moves to PAUSED.
//  Reset mid-count: abandons everything, including the start register.
//  No invalid BCD is ever output.
// STRUCTURE
//  Shared package bytebasher_pkg:
//   BCD_MAX = 4'd9
//   Speed encodings SPD_1X..SPD_8X
//   timer state encodings ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE
//  Sub-module tick_gen (CLOCK_FREQUENCY, CNT_W):
//   ClockIn, Reset, Restart, En, Speed -> Tick
//  BCD up/down chain: generate loop over DIGITS in this module.
// TESTING (CLOCK_FREQUENCY=8, DIGITS=2 unless noted)
//  1. Reset, Load 8'h03, Start, Up=0, Speed=00
//     -> Digits 02,01,00 at 8-cycle spacing; Expired 1 cycle with 00; Done=1, Running=0.
//  2. Load 8'h10, Start, down -> 09 after first tick (borrow ripple); later ticks give 08, 07.
//  3. Load 8'h97, Up=1, Start -> 98, then 99 with Expired; Start from DONE reloads 97, Running=1.
//  4. Pause held 20 cycles mid-period at 05 -> Digits stay 05; remaining partial period completes after release.
//  5. Speed=11 -> tick every 1 cycle; Speed=01 -> every 4 cycles; change mid-period applies after next tick.
//  6. Load 8'hAF -> Digits=99. Reset during RUN -> Digits=00, IDLE, all flags low next cycle.
//     Load+Start same cycle -> IDLE.

Source files
------------

// File: rtl/bytebasher_pkg.sv
// Shared definitions for the BCD game timer.
//   BCD_MAX        largest legal BCD digit
//   speed_e        tick-rate selector encodings (divider shift amount)
//   timer_state_e  game timer FSM state encodings
package bytebasher_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        SPD_1X = 2'd0,
        SPD_2X = 2'd1,
        SPD_4X = 2'd2,
        SPD_8X = 2'd3
    } speed_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } timer_state_e;

endpackage

// File: rtl/bcd_game_timer_tick_gen.sv
// tick_gen: programmable-rate tick generator for the BCD game timer.
//   ClockIn  in  system clock
//   Reset    in  synchronous active-high reset (divider loads period-1)
//   Restart  in  reload the divider with period-1
//   En       in  count enable; when low the divider holds its value
//   Speed    in  rate select, period = CLOCK_FREQUENCY >> Speed
//   Tick     out one-cycle pulse when an enabled divider reaches zero
module tick_gen
    import bytebasher_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int CNT_W           = 27
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Restart,
    input  logic       En,
    input  logic [1:0] Speed,
    output logic       Tick
);

    localparam logic [CNT_W-1:0] FREQ = CNT_W'(CLOCK_FREQUENCY);

    logic [CNT_W-1:0] cnt_q, cnt_d, reload;

    // Speed is only consulted at reload, so a rate change never cuts a
    // running period short.
    assign reload = (FREQ >> Speed) - CNT_W'(1);
    assign Tick   = En && (cnt_q == '0);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (Restart) begin
            cnt_d = reload;
        end else if (En) begin
            cnt_d = (cnt_q == '0) ? reload : cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge ClockIn) begin
        if (Reset) cnt_q <= reload;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bcd_game_timer.sv
// bcd_game_timer: run/pause/done BCD timer over DIGITS decimal digits.
//   ClockIn    in  system clock
//   Reset      in  synchronous active-high reset
//   Load       in  strobe: capture clamped LoadValue, go IDLE
//   LoadValue  in  BCD start value, digit 0 in [3:0]
//   Start      in  strobe: IDLE/DONE -> RUN, latches Up
//   Pause      in  level: hold the count while high
//   Up         in  count direction (1 = up)
//   Speed      in  tick rate 1x/2x/4x/8x
//   Digits     out current BCD count
//   Running    out high in RUN
//   Expired    out one-cycle pulse on reaching the terminal value
//   Done       out high in DONE
module bcd_game_timer
    import bytebasher_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int DIGITS          = 2,
    parameter int CNT_W           = 27
) (
    input  logic                ClockIn,
    input  logic                Reset,
    input  logic                Load,
    input  logic [4*DIGITS-1:0] LoadValue,
    input  logic                Start,
    input  logic                Pause,
    input  logic                Up,
    input  logic [1:0]          Speed,
    output logic [4*DIGITS-1:0] Digits,
    output logic                Running,
    output logic                Expired,
    output logic                Done
);

    timer_state_e        state_q, state_d;
    logic [4*DIGITS-1:0] digits_q, digits_d, start_q, start_d;
    logic                up_q, up_d, expired_q, expired_d;
    logic                restart, tick, start_ok;

    logic [4*DIGITS-1:0] cur, inc, dec, nxt, clamped;
    logic [DIGITS-1:0]   carry, borrow, cur_nine, cur_zero, nxt_nine, nxt_zero;

    // Leaving DONE restarts from the stored start value, so the arithmetic
    // and terminal checks work on whatever value the next cycle will count from.
    assign cur = (state_q == ST_DONE) ? start_q : digits_q;
    assign nxt = up_q ? inc : dec;
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_bcd
        logic [3:0] d, lv;
        assign d  = cur[4*g +: 4];
        assign lv = LoadValue[4*g +: 4];

        assign inc[4*g +: 4]     = !carry[g]  ? d : (d == BCD_MAX) ? 4'd0 : d + 4'd1;
        assign dec[4*g +: 4]     = !borrow[g] ? d : (d == 4'd0) ? BCD_MAX : d - 4'd1;
        assign clamped[4*g +: 4] = (lv > BCD_MAX) ? BCD_MAX : lv;

        assign cur_nine[g] = (d == BCD_MAX);
        assign cur_zero[g] = (d == 4'd0);
        assign nxt_nine[g] = (nxt[4*g +: 4] == BCD_MAX);
        assign nxt_zero[g] = (nxt[4*g +: 4] == 4'd0);

        if (g < DIGITS - 1) begin : g_ripple
            assign carry[g+1]  = carry[g]  && (d == BCD_MAX);
            assign borrow[g+1] = borrow[g] && (d == 4'd0);
        end
    end

    assign start_ok = Start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign restart  = Load || start_ok;

    tick_gen #(
        .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
        .CNT_W           (CNT_W)
    ) u_tick_gen (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .Restart (restart),
        .En      (state_q == ST_RUN),
        .Speed   (Speed),
        .Tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        start_d   = start_q;
        up_d      = up_q;
        expired_d = 1'b0;
        if (Load) begin
            state_d  = ST_IDLE;
            digits_d = clamped;
            start_d  = clamped;
        end else if (start_ok) begin
            up_d     = Up;
            digits_d = cur;
            if (Up ? &cur_nine : &cur_zero) begin
                state_d   = ST_DONE;
                expired_d = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_RUN) begin
            if (tick) begin
                digits_d = nxt;
                if (up_q ? &nxt_nine : &nxt_zero) begin
                    state_d   = ST_DONE;
                    expired_d = 1'b1;
                end else if (Pause) begin
                    state_d = ST_PAUSED;
                end
            end else if (Pause) begin
                state_d = ST_PAUSED;
            end
        end else if (state_q == ST_PAUSED && !Pause) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            digits_q  <= '0;
            start_q   <= '0;
            up_q      <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            start_q   <= start_d;
            up_q      <= up_d;
            expired_q <= expired_d;
        end
    end

    assign Digits  = digits_q;
    assign Running = (state_q == ST_RUN);
    assign Done    = (state_q == ST_DONE);
    assign Expired = expired_q;

endmodule

// File: tb/tb_bcd_game_timer.sv
// Directed testbench for bcd_game_timer (CLOCK_FREQUENCY=8, DIGITS=2).
module tb_bcd_game_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       up = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [7:0] digits;
    logic       running, expired, done;

    int total = 0;
    int bad   = 0;

    bcd_game_timer #(
        .CLOCK_FREQUENCY (8),
        .DIGITS          (2),
        .CNT_W           (4)
    ) dut (
        .ClockIn   (clk),
        .Reset     (rst),
        .Load      (load),
        .LoadValue (load_value),
        .Start     (start),
        .Pause     (pause),
        .Up        (up),
        .Speed     (speed),
        .Digits    (digits),
        .Running   (running),
        .Expired   (expired),
        .Done      (done)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load_value = v;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start(input logic dir);
        up = dir;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        // 1: reset, count 03 down to 00
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check("rst_digits", digits, 8'h00);
        check("rst_flags", {running, expired, done}, 3'b000);
        do_load(8'h03);
        check("load03", digits, 8'h03);
        do_start(1'b0);
        check("t1_running", running, 1'b1);
        step(7);
        check("t1_hold03", digits, 8'h03);
        step(1);
        check("t1_02", digits, 8'h02);
        step(8);
        check("t1_01", digits, 8'h01);
        step(8);
        check("t1_00", digits, 8'h00);
        check("t1_exp_flags", {running, expired, done}, 3'b011);
        step(1);
        check("t1_exp_pulse", {running, expired, done}, 3'b001);
        step(10);
        check("t1_frozen", digits, 8'h00);

        // 2: borrow ripple from 10
        do_load(8'h10);
        do_start(1'b0);
        step(8);
        check("t2_09", digits, 8'h09);
        step(8);
        check("t2_08", digits, 8'h08);
        step(8);
        check("t2_07", digits, 8'h07);

        // 3: count up to 99, restart from DONE
        do_load(8'h97);
        do_start(1'b1);
        step(8);
        check("t3_98", digits, 8'h98);
        step(8);
        check("t3_99", digits, 8'h99);
        check("t3_exp_flags", {running, expired, done}, 3'b011);
        step(1);
        do_start(1'b1);
        check("t3_reload", digits, 8'h97);
        check("t3_rerun", {running, expired, done}, 3'b100);

        // 4: pause mid-period preserves the partial period
        do_load(8'h06);
        do_start(1'b0);
        step(8);
        check("t4_05", digits, 8'h05);
        step(3);
        pause = 1'b1;
        step(20);
        check("t4_paused_digits", digits, 8'h05);
        check("t4_paused_run", running, 1'b0);
        pause = 1'b0;
        step(1);
        check("t4_resume", {running, digits}, {1'b1, 8'h05});
        step(3);
        check("t4_partial", digits, 8'h05);
        step(1);
        check("t4_04", digits, 8'h04);

        // 5: speed selection and mid-period change
        do_load(8'h99);
        speed = 2'd3;
        do_start(1'b0);
        step(1);
        check("t5_8x_a", digits, 8'h98);
        step(1);
        check("t5_8x_b", digits, 8'h97);
        speed = 2'd1;
        step(1);
        check("t5_2x_first", digits, 8'h96);
        step(3);
        check("t5_2x_hold", digits, 8'h96);
        step(1);
        check("t5_2x_tick", digits, 8'h95);
        speed = 2'd3;
        step(3);
        check("t5_change_hold", digits, 8'h95);
        step(1);
        check("t5_change_tick", digits, 8'h94);
        step(1);
        check("t5_change_8x", digits, 8'h93);
        speed = 2'd0;

        // 6: clamp, reset mid-run, Load+Start, start on terminal
        do_load(8'hAF);
        check("t6_clamp", digits, 8'h99);
        do_start(1'b0);
        check("t6_run", running, 1'b1);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_rst_digits", digits, 8'h00);
        check("t6_rst_flags", {running, expired, done}, 3'b000);
        load_value = 8'h05;
        load = 1'b1;
        start = 1'b1;
        up = 1'b0;
        step(1);
        load = 1'b0;
        start = 1'b0;
        check("t6_ldst_digits", digits, 8'h05);
        check("t6_ldst_flags", {running, expired, done}, 3'b000);
        step(10);
        check("t6_idle_hold", digits, 8'h05);
        do_load(8'h00);
        do_start(1'b0);
        check("t6_term_start", {running, expired, done, digits}, {3'b011, 8'h00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
